ccm_output_bank: RTL

- Parametrised multi-channel Capture/Compare output unit for the TimerA/TimerB family.
- Drives NCH OUTn pins from per-channel OUTMOD (8 standard modes) with EQU0/EQUn events.
- Adds shadowed (double-buffered) OUTMOD loading under group load policy CLLD, and glitch-free entry from mode OUT into a registered mode.
- Sits between the CCM compare blocks and the PIN module.

---
 rtl/ccm_output_bank_pkg.sv | 42 ++++
 rtl/ccm_output_bank_channel.sv | 76 +++++++
 rtl/ccm_output_bank.sv | 41 ++++
 3 files changed

// File: rtl/ccm_output_bank_pkg.sv
// Shared encodings and the per-mode OutQ update for the CCM output bank.
// Optional dead-time feature: CCM_DEADTIME_EN.
package ccm_output_bank_pkg;

  localparam int OUTMOD_W = 3;

  localparam logic [2:0] OUTMOD_OUT     = 3'd0;
  localparam logic [2:0] OUTMOD_SET     = 3'd1;
  localparam logic [2:0] OUTMOD_TOG_RST = 3'd2;
  localparam logic [2:0] OUTMOD_SET_RST = 3'd3;
  localparam logic [2:0] OUTMOD_TOG     = 3'd4;
  localparam logic [2:0] OUTMOD_RST     = 3'd5;
  localparam logic [2:0] OUTMOD_TOG_SET = 3'd6;
  localparam logic [2:0] OUTMOD_RST_SET = 3'd7;

  localparam logic [1:0] CLLD_IMMED        = 2'd0;
  localparam logic [1:0] CLLD_ON_EQU0      = 2'd1;
  localparam logic [1:0] CLLD_ON_EQU0_OR_N = 2'd2;
  localparam logic [1:0] CLLD_ON_EQUN      = 2'd3;

  function automatic logic outq_next(
    input logic [OUTMOD_W-1:0] mode,
    input logic                q,
    input logic                e0,
    input logic                en
  );
    logic r;
    r = q;
    unique case (mode)
      OUTMOD_OUT:     r = q;
      OUTMOD_SET:     r = q | en;
      OUTMOD_TOG_RST: r = ~e0 & (en ^ q);
      OUTMOD_SET_RST: r = ~e0 & (en | q);
      OUTMOD_TOG:     r = q ^ en;
      OUTMOD_RST:     r = ~en & q;
      OUTMOD_TOG_SET: r = e0 | (en ^ q);
      OUTMOD_RST_SET: r = e0 | (~en & q);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ccm_output_bank_channel.sv
// One CCM output channel: shadowed OUTMOD, OutQ, OUT-mode mux.
// With CCM_DEADTIME_EN, rising edges are delayed by i_dt cycles.
module ccm_output_channel
  import ccm_output_bank_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic                TimerClock,
  input  logic                reset,
  input  logic                i_e0,
  input  logic                i_en,
  input  logic                i_wout,
  input  logic [OUTMOD_W-1:0] i_outmod,
  input  logic [1:0]          i_clld,
`ifdef CCM_DEADTIME_EN
  input  logic [DT_W-1:0]     i_dt,
`endif
  output logic [OUTMOD_W-1:0] o_outmod_act,
  output logic                o_out
);

  logic [OUTMOD_W-1:0] r_mode;
  logic                r_outq;
  logic                w_load;
  logic [OUTMOD_W-1:0] w_mode_nxt;
  logic                w_mux;

  always_comb begin
    w_load = 1'b0;
    unique case (i_clld)
      CLLD_IMMED:        w_load = 1'b1;
      CLLD_ON_EQU0:      w_load = i_e0;
      CLLD_ON_EQU0_OR_N: w_load = i_e0 | i_en;
      CLLD_ON_EQUN:      w_load = i_en;
    endcase
  end

  assign w_mode_nxt = w_load ? i_outmod : r_mode;

  // Leaving OUT mode seeds OutQ from wOUT so the pin does not glitch.
  always_ff @(posedge TimerClock or posedge reset) begin
    if (reset) begin
      r_mode <= OUTMOD_OUT;
      r_outq <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      if (r_mode == OUTMOD_OUT && w_mode_nxt != OUTMOD_OUT)
        r_outq <= i_wout;
      else
        r_outq <= outq_next(r_mode, r_outq, i_e0, i_en);
    end
  end

  assign w_mux = (r_mode == OUTMOD_OUT) ? (i_wout & ~reset) : r_outq;
  assign o_outmod_act = r_mode;

`ifdef CCM_DEADTIME_EN
  logic [DT_W-1:0] r_cnt;

  always_ff @(posedge TimerClock or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (!w_mux)
      r_cnt <= '0;
    else if (r_cnt < i_dt)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_out = w_mux & (r_cnt >= i_dt) & ~reset;
`else
  if (DT_W < 1) begin : g_dtw_chk
  end
  assign o_out = w_mux;
`endif

endmodule

// File: rtl/ccm_output_bank.sv
// Multi-channel CCM output bank: NCH channels with shared CLLD policy.
// Optional per-channel dead time: CCM_DEADTIME_EN.
module ccm_output_bank
  import ccm_output_bank_pkg::*;
#(
  parameter int NCH  = 7,
  parameter int DT_W = 8
) (
  input  logic                    TimerClock,
  input  logic                    reset,
  input  logic [NCH-1:0]          EQU,
  input  logic [NCH-1:0]          wOUT,
  input  logic [OUTMOD_W*NCH-1:0] OUTMOD_in,
  input  logic [1:0]              CLLD,
`ifdef CCM_DEADTIME_EN
  input  logic [DT_W-1:0]         DT,
`endif
  output logic [OUTMOD_W*NCH-1:0] OUTMOD_act,
  output logic [NCH-1:0]          OUTn
);

  for (genvar m = 0; m < NCH; m++) begin : g_ch
    ccm_output_channel #(
      .DT_W(DT_W)
    ) u_ch (
      .TimerClock  (TimerClock),
      .reset       (reset),
      .i_e0        (EQU[0]),
      .i_en        (EQU[m]),
      .i_wout      (wOUT[m]),
      .i_outmod    (OUTMOD_in[OUTMOD_W*m +: OUTMOD_W]),
      .i_clld      (CLLD),
`ifdef CCM_DEADTIME_EN
      .i_dt        (DT),
`endif
      .o_outmod_act(OUTMOD_act[OUTMOD_W*m +: OUTMOD_W]),
      .o_out       (OUTn[m])
    );
  end

endmodule
